// File: rtl/alu_sequencer.sv
// alu_sequencer: valid/ready front end that runs one ALU operation, or a
// chained MLO/MHI pair for a 16-bit product, and returns the sampled result.
module alu_sequencer #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  // command channel
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_mode,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic        cmd_wide,
  // response channel
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_carry,
  output logic        rsp_zero,
  // ALU side
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_mode,
  output logic        alu_ee,
  output logic        alu_eo,
  input  logic [7:0]  alu_out,
  input  logic        alu_carry,
  input  logic        alu_zero
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned MODE_W = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned RSP_W  = 2 * DATA_W;

  localparam logic [MODE_W-1:0] MODE_MLO = 4'b1101;
  localparam logic [MODE_W-1:0] MODE_MHI = 4'b1110;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC_LO = 2'd1,
    EXEC_HI = 2'd2,
    RESP    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic                wide_q, wide_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                ee_q, ee_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [RSP_W-1:0]    rsp_data_q, rsp_data_d;
  logic                rsp_carry_q, rsp_carry_d;
  logic                rsp_zero_q, rsp_zero_d;

  // The ALU zero flag only covers 8 bits; the 16-bit zero is recomputed here.
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;

  // State and datapath registers; async reset aborts any op in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= '0;
      wide_q      <= 1'b0;
      lo_q        <= '0;
      ee_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      wide_q      <= wide_d;
      lo_q        <= lo_d;
      ee_q        <= ee_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

  // Next-state, phase counting and result capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    mode_d      = mode_q;
    wide_d      = wide_q;
    lo_d        = lo_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_zero_d  = rsp_zero_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          wide_d  = cmd_wide;
          mode_d  = cmd_wide ? MODE_MLO : cmd_mode;
          cnt_d   = CNT_LOAD;
          state_d = EXEC_LO;
        end
      end

      EXEC_LO: begin
        if (cnt_q == '0) begin
          lo_d        = alu_out;
          rsp_carry_d = alu_carry;
          if (wide_q) begin
            // Operands stay put; only the mode flips to the high product byte.
            mode_d  = MODE_MHI;
            cnt_d   = CNT_LOAD;
            state_d = EXEC_HI;
          end else begin
            rsp_data_d = {DATA_W'(0), alu_out};
            rsp_zero_d = ~|alu_out;
            state_d    = RESP;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      EXEC_HI: begin
        if (cnt_q == '0) begin
          rsp_data_d  = {alu_out, lo_q};
          rsp_carry_d = alu_carry;
          rsp_zero_d  = ~|{alu_out, lo_q};
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Enables and response valid track the state being entered so they are registered.
  always_comb begin
    ee_d        = 1'b0;
    rsp_valid_d = 1'b0;
    if ((state_d == EXEC_LO) || (state_d == EXEC_HI)) begin
      ee_d = 1'b1;
    end
    if (state_d == RESP) begin
      rsp_valid_d = 1'b1;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_zero  = rsp_zero_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_mode  = mode_q;
  assign alu_ee    = ee_q;
  assign alu_eo    = ee_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: two instances (EXEC_CYCLES 1 and 3)
// each driving a behavioural ALU; directed vectors with hand-computed results.
module tb_alu_sequencer;

  logic        clk;
  logic        reset;
  logic        rsp_ready;
  logic [3:0]  cmd_mode;
  logic [7:0]  cmd_a, cmd_b;
  logic        cmd_wide;

  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_data  [2];
  logic        rsp_carry [2];
  logic        rsp_zero  [2];
  logic [7:0]  alu_a     [2];
  logic [7:0]  alu_b     [2];
  logic [3:0]  alu_mode  [2];
  logic        alu_ee    [2];
  logic        alu_eo    [2];
  logic [7:0]  alu_out   [2];
  logic        alu_carry [2];
  logic        alu_zero  [2];

  typedef struct {
    logic [15:0] data;
    logic        carry;
    logic        zero;
    int          dut;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: 1101 low product byte, 1110 high product byte,
  // 1111 integer sqrt of a, anything else add.
  function automatic logic [8:0] alu_f(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    int s;
    p = 16'(a) * 16'(b);
    case (m)
      4'b1101: return {|p[15:8], p[7:0]};
      4'b1110: return {1'b0, p[15:8]};
      4'b1111: begin
        s = 0;
        while ((s + 1) * (s + 1) <= int'(a)) s++;
        return {(s * s) != int'(a), 8'(s)};
      end
      default: return 9'(a) + 9'(b);
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [8:0] r;
    assign r            = alu_f(alu_mode[g], alu_a[g], alu_b[g]);
    assign alu_out[g]   = alu_eo[g] ? r[7:0] : 8'h00;
    assign alu_carry[g] = alu_ee[g] ? r[8] : 1'b0;
    assign alu_zero[g]  = (alu_out[g] == 8'h00);

    alu_sequencer #(.EXEC_CYCLES((g == 0) ? 1 : 3)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid[g]),
      .cmd_ready (cmd_ready[g]),
      .cmd_mode  (cmd_mode),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_wide  (cmd_wide),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data[g]),
      .rsp_carry (rsp_carry[g]),
      .rsp_zero  (rsp_zero[g]),
      .alu_a     (alu_a[g]),
      .alu_b     (alu_b[g]),
      .alu_mode  (alu_mode[g]),
      .alu_ee    (alu_ee[g]),
      .alu_eo    (alu_eo[g]),
      .alu_out   (alu_out[g]),
      .alu_carry (alu_carry[g]),
      .alu_zero  (alu_zero[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pop and compare on every response handshake.
  always @(negedge clk) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        if (rsp_valid[d] && rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("rsp_unexpected_dut%0d", d), 32'(rsp_data[d]), 32'hFFFF_FFFF);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_dut",   32'(d),            32'(e.dut));
            chk("rsp_data",  32'(rsp_data[d]),  32'(e.data));
            chk("rsp_carry", 32'(rsp_carry[d]), 32'(e.carry));
            chk("rsp_zero",  32'(rsp_zero[d]),  32'(e.zero));
          end
        end
      end
    end
  end

  task automatic chk_reset_vals(input int d);
    chk("rst_cmd_ready", 32'(cmd_ready[d]), 32'd1);
    chk("rst_ee_eo",     32'({alu_ee[d], alu_eo[d]}), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    chk("rst_rsp",       32'({rsp_data[d], rsp_carry[d], rsp_zero[d]}), 32'd0);
    chk("rst_alu_ops",   32'({alu_a[d], alu_b[d], alu_mode[d]}), 32'd0);
  endtask

  // Issue one command on dut d, check timing/enables, then release or hold the response.
  task automatic do_op(input int d, input logic [3:0] m, input logic [7:0] a, input logic [7:0] b,
                       input logic w, input logic [15:0] ed, input logic ec, input logic ez,
                       input int hold);
    int ecyc, lat, ee_n, cr_bad, op_bad, hold_bad;
    logic [3:0] first_mode, last_mode;
    logic [15:0] snap;
    logic seen;
    ecyc = (d == 0) ? 1 : 3;
    lat = 0; ee_n = 0; cr_bad = 0; op_bad = 0; hold_bad = 0; seen = 1'b0;
    first_mode = 4'h0; last_mode = 4'h0;
    @(negedge clk);
    chk("cmd_ready_idle", 32'(cmd_ready[d]), 32'd1);
    cmd_mode = m; cmd_a = a; cmd_b = b; cmd_wide = w;
    cmd_valid[d] = 1'b1;
    rsp_ready = (hold == 0);
    exp_q.push_back('{ed, ec, ez, d});
    @(posedge clk);
    #1;
    cmd_valid[d] = 1'b0;
    cmd_mode = ~m; cmd_a = ~a; cmd_b = ~b; cmd_wide = ~w;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk);
      if (alu_ee[d]) begin
        if (ee_n == 0) first_mode = alu_mode[d];
        last_mode = alu_mode[d];
        ee_n++;
        if (alu_a[d] != a || alu_b[d] != b || !alu_eo[d]) op_bad++;
      end
      if (cmd_ready[d]) cr_bad++;
      if (rsp_valid[d]) begin
        seen = 1'b1;
        lat = k;
      end
    end
    chk("ee_cycles",     32'(ee_n),   32'(ecyc * (w ? 2 : 1)));
    chk("rsp_latency",   32'(lat),    32'(ecyc * (w ? 2 : 1) + 1));
    chk("busy_cmd_rdy",  32'(cr_bad), 32'd0);
    chk("exec_operands", 32'(op_bad), 32'd0);
    chk("mode_first",    32'(first_mode), 32'(w ? 4'b1101 : m));
    chk("mode_last",     32'(last_mode),  32'(w ? 4'b1110 : m));
    if (hold > 0) begin
      snap = rsp_data[d];
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (!rsp_valid[d] || rsp_data[d] != snap || cmd_ready[d] || alu_ee[d]) hold_bad++;
      end
      chk("hold_stable", 32'(hold_bad), 32'd0);
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("post_rsp_cmd_ready", 32'({cmd_ready[d], rsp_valid[d]}), 32'b10);
  endtask

  initial begin
    reset = 1'b0;
    rsp_ready = 1'b0;
    cmd_mode = 4'h0; cmd_a = 8'h00; cmd_b = 8'h00; cmd_wide = 1'b0;
    cmd_valid[0] = 1'b0;
    cmd_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals(0);
    chk_reset_vals(1);
    reset = 1'b1;

    // EXEC_CYCLES = 1
    do_op(0, 4'b1101, 8'h80, 8'h80, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
    do_op(0, 4'b0011, 8'h80, 8'h80, 1'b1, 16'h4000, 1'b0, 1'b0, 0);
    do_op(0, 4'b1111, 8'h04, 8'h00, 1'b0, 16'h0002, 1'b0, 1'b0, 0);
    do_op(0, 4'b1111, 8'h05, 8'h00, 1'b0, 16'h0002, 1'b1, 1'b0, 0);
    do_op(0, 4'b0000, 8'hF0, 8'h10, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
    // EXEC_CYCLES = 3
    do_op(1, 4'b0000, 8'hFF, 8'hFF, 1'b1, 16'hFE01, 1'b0, 1'b0, 0);
    do_op(1, 4'b0000, 8'h12, 8'h34, 1'b0, 16'h0046, 1'b0, 1'b0, 5);

    // Abort a wide op during its high phase; no response may appear.
    @(negedge clk);
    cmd_mode = 4'h0; cmd_a = 8'h33; cmd_b = 8'h44; cmd_wide = 1'b1;
    cmd_valid[1] = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid[1] = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_in_mhi", 32'({alu_ee[1], alu_mode[1]}), 32'({1'b1, 4'b1110}));
    reset = 1'b0;
    #1;
    chk_reset_vals(1);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_rsp", 32'(rsp_valid[1]), 32'd0);
    do_op(1, 4'b0000, 8'h01, 8'h02, 1'b0, 16'h0003, 1'b0, 1'b0, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
